// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game: state codes used by both the
// game FSM and the datapath, plus small decode helpers.
package whack_pkg;

    typedef enum logic [3:0] {
        ST_START    = 4'd0,
        ST_GAME     = 4'd1,
        ST_MOLE1    = 4'd2,
        ST_MOLE2    = 4'd3,
        ST_MOLE3    = 4'd4,
        ST_MOLE4    = 4'd5,
        ST_GAMEOVER = 4'd6
    } game_state_e;

    // Map a raw 4-bit state code onto a legal state; unused codes mean Start.
    function automatic game_state_e decode_state(input logic [3:0] code);
        if (code > 4'd6) begin
            return ST_START;
        end
        return game_state_e'(code);
    endfunction

    // One-hot mask of the mole that belongs to a state (zero outside Mole1-4).
    function automatic logic [3:0] mole_mask(input game_state_e st);
        logic [3:0] mask;
        case (st)
            ST_MOLE1: mask = 4'b0001;
            ST_MOLE2: mask = 4'b0010;
            ST_MOLE3: mask = 4'b0100;
            ST_MOLE4: mask = 4'b1000;
            default:  mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Per-bit two-flop synchronizer followed by a rising-edge detector for the
// raw mole buttons. The rise output is a one-cycle pulse.
module key_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] rise
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic meta_reg;
        logic sync_reg;
        logic last_reg;

        // Two synchronizing stages plus one history stage for edge detection.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                meta_reg <= 1'b0;
                sync_reg <= 1'b0;
                last_reg <= 1'b0;
            end else begin
                meta_reg <= raw[gi];
                sync_reg <= meta_reg;
                last_reg <= sync_reg;
            end
        end

        assign rise[gi] = sync_reg & ~last_reg;
    end

endmodule

// File: rtl/mole_datapath.sv
// Whack-a-mole datapath: game clock, gap and mole timers, hit detection,
// score/miss counters and the pulse handshake back to the game FSM.
module mole_datapath
    import whack_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int GAME_SECONDS = 60,
    parameter int GAP_TICKS    = 25000000,
    parameter int MOLE_TICKS   = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] state,
    input  logic [3:0] key,
    output logic       control_signal,
    output logic       timer_signal,
    output logic       delay_done,
    output logic [3:0] mole_led,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic [6:0] time_left
);

    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int GAP_W   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int MOLE_W  = (MOLE_TICKS > 1) ? $clog2(MOLE_TICKS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_TICKS - 1);
    localparam logic [MOLE_W-1:0]  MOLE_LAST  = MOLE_W'(MOLE_TICKS - 1);
    localparam logic [6:0]         SECONDS    = 7'(GAME_SECONDS);

    logic [3:0]         key_hit;
    game_state_e        cur_state;
    game_state_e        prev_state_reg;
    game_state_e        suppress_state_reg;
    logic               suppress_reg;
    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next, gap_base;
    logic [MOLE_W-1:0]  mole_cnt_reg, mole_cnt_next, mole_base;
    logic [6:0]         time_left_reg, time_left_next;
    logic [7:0]         score_reg, score_next, misses_reg, misses_next;
    logic [3:0]         mole_sel, mole_led_reg;
    logic               control_reg, control_next, delay_done_reg, delay_done_next;
    logic               timer_reg, timer_next;
    logic               is_start, is_game, is_mole, is_running, state_changed;
    logic               suppress_active, time_expired, sec_tick;
    logic               gap_term, mole_term, hit;
    logic               gap_fire, abort_fire, hit_fire, miss_fire;

    key_sync #(.WIDTH(4)) u_key_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (key),
        .rise  (key_hit)
    );

    assign cur_state       = decode_state(state);
    assign mole_sel        = mole_mask(cur_state);
    assign is_start        = (cur_state == ST_START);
    assign is_game         = (cur_state == ST_GAME);
    assign is_mole         = |mole_sel;
    assign is_running      = is_game || is_mole;
    assign state_changed   = (cur_state != prev_state_reg);
    assign suppress_active = suppress_reg && (cur_state == suppress_state_reg);
    assign time_expired    = (time_left_reg == 7'd0);
    assign hit             = |(key_hit & mole_sel);

    // Next-state logic for timers, counters and the FSM handshake pulses.
    always_comb begin
        // A state change restarts the per-state timers from zero this cycle.
        gap_base  = state_changed ? '0 : gap_cnt_reg;
        mole_base = state_changed ? '0 : mole_cnt_reg;
        gap_term  = is_game && (gap_base == GAP_LAST);
        mole_term = is_mole && (mole_base == MOLE_LAST);

        // Terminal counts hold; the suppress flag keeps them from re-firing.
        gap_cnt_next = '0;
        if (is_game) begin
            gap_cnt_next = gap_term ? gap_base : gap_base + 1'b1;
        end
        mole_cnt_next = '0;
        if (is_mole) begin
            mole_cnt_next = mole_term ? mole_base : mole_base + 1'b1;
        end

        sec_tick   = is_running && (presc_reg == PRESC_LAST);
        presc_next = '0;
        if (is_running && !sec_tick) begin
            presc_next = presc_reg + 1'b1;
        end

        time_left_next = time_left_reg;
        if (is_start) begin
            time_left_next = SECONDS;
        end else if (sec_tick && !time_expired) begin
            time_left_next = time_left_reg - 7'd1;
        end
        timer_next = (time_left_next == 7'd0) && !is_start;

        // Expired time aborts a mole; otherwise a hit beats a same-cycle timeout.
        gap_fire   = gap_term && !time_expired && !suppress_active;
        abort_fire = is_mole && time_expired && !suppress_active;
        hit_fire   = is_mole && !time_expired && hit && !suppress_active;
        miss_fire  = mole_term && !time_expired && !hit && !suppress_active;

        control_next    = gap_fire || abort_fire || hit_fire || miss_fire;
        delay_done_next = gap_fire;

        score_next  = score_reg;
        misses_next = misses_reg;
        if (is_start) begin
            score_next  = 8'd0;
            misses_next = 8'd0;
        end else begin
            if (hit_fire && (score_reg != 8'hFF)) begin
                score_next = score_reg + 8'd1;
            end
            if (miss_fire && (misses_reg != 8'hFF)) begin
                misses_next = misses_reg + 8'd1;
            end
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_state_reg     <= ST_START;
            suppress_state_reg <= ST_START;
            suppress_reg       <= 1'b0;
            presc_reg          <= '0;
            gap_cnt_reg        <= '0;
            mole_cnt_reg       <= '0;
            time_left_reg      <= SECONDS;
            score_reg          <= 8'd0;
            misses_reg         <= 8'd0;
            mole_led_reg       <= 4'd0;
            control_reg        <= 1'b0;
            delay_done_reg     <= 1'b0;
            timer_reg          <= 1'b0;
        end else begin
            prev_state_reg <= cur_state;
            if (control_next) begin
                suppress_reg       <= 1'b1;
                suppress_state_reg <= cur_state;
            end else if (cur_state != suppress_state_reg) begin
                suppress_reg <= 1'b0;
            end
            presc_reg      <= presc_next;
            gap_cnt_reg    <= gap_cnt_next;
            mole_cnt_reg   <= mole_cnt_next;
            time_left_reg  <= time_left_next;
            score_reg      <= score_next;
            misses_reg     <= misses_next;
            mole_led_reg   <= mole_sel;
            control_reg    <= control_next;
            delay_done_reg <= delay_done_next;
            timer_reg      <= timer_next;
        end
    end

    assign control_signal = control_reg;
    assign delay_done     = delay_done_reg;
    assign timer_signal   = timer_reg;
    assign mole_led       = mole_led_reg;
    assign score          = score_reg;
    assign misses         = misses_reg;
    assign time_left      = time_left_reg;

endmodule

// File: tb/tb_mole_datapath.sv
// Self-checking bench for mole_datapath with small timing parameters.
// Expected values come from arithmetic on the game rules: key-to-control
// latency 3, gap pulse GAP_TICKS cycles after entering Game, mole timeout
// MOLE_TICKS cycles after entering a mole, one second per CLK_HZ running cycles.
module tb_mole_datapath;

    localparam int CLK_HZ       = 10;
    localparam int GAME_SECONDS = 3;
    localparam int GAP_TICKS    = 4;
    localparam int MOLE_TICKS   = 8;
    localparam int KEY_LAT      = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] state = 4'd0;
    logic [3:0] key = 4'd0;
    logic       control_signal, timer_signal, delay_done;
    logic [3:0] mole_led;
    logic [7:0] score, misses;
    logic [6:0] time_left;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mole_datapath #(
        .CLK_HZ       (CLK_HZ),
        .GAME_SECONDS (GAME_SECONDS),
        .GAP_TICKS    (GAP_TICKS),
        .MOLE_TICKS   (MOLE_TICKS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .state          (state),
        .key            (key),
        .control_signal (control_signal),
        .timer_signal   (timer_signal),
        .delay_done     (delay_done),
        .mole_led       (mole_led),
        .score          (score),
        .misses         (misses),
        .time_left      (time_left)
    );

    // Every task starts and ends 1 ns after a rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_state(input logic [3:0] s, input int n);
        state = s;
        repeat (n) next_cycle();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({control_signal, delay_done, timer_signal} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses got %b exp 000", {control_signal, delay_done, timer_signal});
        end
        checks++;
        if ({mole_led, score, misses} !== 20'd0) begin
            errors++;
            $display("FAIL reset_counts got led=%b score=%0d misses=%0d exp 0", mole_led, score, misses);
        end
        checks++;
        if (time_left !== 7'(GAME_SECONDS)) begin
            errors++;
            $display("FAIL reset_time got %0d exp %0d", time_left, GAME_SECONDS);
        end
        reset = 1'b0;
        next_cycle();
        $display("reset: led=%b score=%0d misses=%0d time_left=%0d", mole_led, score, misses, time_left);
    endtask

    // Game state held: exactly one gap pulse, GAP_TICKS cycles after entry.
    task automatic test_gap();
        int hold;
        hold_state(4'd0, 2);
        hold = $urandom_range(12, 18);
        state = 4'd1;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            checks++;
            if (control_signal !== (c == GAP_TICKS)) begin
                errors++;
                $display("FAIL gap_ctrl cycle %0d got %b exp %b", c, control_signal, c == GAP_TICKS);
            end
            checks++;
            if (delay_done !== (c == GAP_TICKS)) begin
                errors++;
                $display("FAIL gap_done cycle %0d got %b exp %b", c, delay_done, c == GAP_TICKS);
            end
            next_cycle();
        end
        $display("gap: held %0d cycles, pulse expected at cycle %0d", hold, GAP_TICKS);
    endtask

    // Random mole rounds: no key, matching key, or wrong key at random cycle j.
    task automatic test_mole_random(input int rounds);
        int exp_score, exp_misses, k, kind, j, other, pulse_c;
        logic [3:0] mask, omask;
        bit hit_wins;
        hold_state(4'd0, 2);
        exp_score  = 0;
        exp_misses = 0;
        for (int r = 0; r < rounds; r++) begin
            key = 4'd0;
            hold_state(4'd6, 2);
            checks++;
            if (mole_led !== 4'd0) begin
                errors++;
                $display("FAIL gameover_led got %b exp 0000", mole_led);
            end
            k     = $urandom_range(1, 4);
            kind  = $urandom_range(0, 2);
            j     = $urandom_range(0, MOLE_TICKS - 1);
            if (r == 0) begin
                kind = 1;
                j    = MOLE_TICKS - KEY_LAT;
            end
            other = (k + $urandom_range(0, 2)) % 4;
            mask  = 4'b0001 << (k - 1);
            omask = 4'b0001 << other;
            hit_wins = (kind == 1) && (j + KEY_LAT <= MOLE_TICKS);
            pulse_c  = hit_wins ? j + KEY_LAT : MOLE_TICKS;
            if (hit_wins) exp_score++;
            else exp_misses++;
            state = 4'(k + 1);
            for (int c = 0; c <= MOLE_TICKS; c++) begin
                if (c == j && kind == 1) key = mask;
                if (c == j && kind == 2) key = omask;
                @(negedge clk);
                checks++;
                if (control_signal !== (c == pulse_c)) begin
                    errors++;
                    $display("FAIL mole_ctrl round %0d cycle %0d got %b exp %b", r, c, control_signal, c == pulse_c);
                end
                if (c >= 1) begin
                    checks++;
                    if (mole_led !== mask) begin
                        errors++;
                        $display("FAIL mole_led round %0d got %b exp %b", r, mole_led, mask);
                    end
                end
                if (c == MOLE_TICKS) begin
                    checks++;
                    if (score !== 8'(exp_score) || misses !== 8'(exp_misses)) begin
                        errors++;
                        $display("FAIL mole_counts round %0d got %0d/%0d exp %0d/%0d",
                                 r, score, misses, exp_score, exp_misses);
                    end
                end
                next_cycle();
            end
            $display("mole round %0d: k=%0d kind=%0d j=%0d pulse@%0d score=%0d misses=%0d",
                     r, k, kind, j, pulse_c, score, misses);
        end
        key = 4'd0;
    endtask

    // Game then a mole across time expiry: countdown, timer level, abort.
    task automatic test_timer();
        int entry, k, exp_t, abort_c;
        logic [3:0] st;
        hold_state(4'd0, 2);
        entry   = $urandom_range(23, 26);
        k       = $urandom_range(1, 4);
        abort_c = ((entry > CLK_HZ * GAME_SECONDS) ? entry : CLK_HZ * GAME_SECONDS) + 1;
        for (int c = 0; c < 36; c++) begin
            st = (c < entry) ? 4'd1 : 4'(k + 1);
            state = st;
            exp_t = GAME_SECONDS - (((c / CLK_HZ) < GAME_SECONDS) ? (c / CLK_HZ) : GAME_SECONDS);
            @(negedge clk);
            checks++;
            if (time_left !== 7'(exp_t)) begin
                errors++;
                $display("FAIL timer_left cycle %0d got %0d exp %0d", c, time_left, exp_t);
            end
            checks++;
            if (timer_signal !== (exp_t == 0)) begin
                errors++;
                $display("FAIL timer_sig cycle %0d got %b exp %b", c, timer_signal, exp_t == 0);
            end
            checks++;
            if (control_signal !== (c == GAP_TICKS || c == abort_c)) begin
                errors++;
                $display("FAIL timer_ctrl cycle %0d got %b exp %b", c, control_signal,
                         c == GAP_TICKS || c == abort_c);
            end
            next_cycle();
        end
        checks++;
        if (score !== 8'd0 || misses !== 8'd0) begin
            errors++;
            $display("FAIL abort_counts got %0d/%0d exp 0/0", score, misses);
        end
        hold_state(4'd0, 2);
        checks++;
        if (timer_signal !== 1'b0 || time_left !== 7'(GAME_SECONDS)) begin
            errors++;
            $display("FAIL timer_restart got sig=%b left=%0d exp 0/%0d", timer_signal, time_left, GAME_SECONDS);
        end
        $display("timer: mole entry %0d, abort pulse expected at cycle %0d", entry, abort_c);
    endtask

    // 256 quick hits: score saturates at 255; then an undefined code acts as Start.
    task automatic test_saturate();
        int k, exp_s;
        logic [3:0] mask;
        hold_state(4'd0, 2);
        for (int r = 0; r < 256; r++) begin
            key = 4'd0;
            hold_state(4'd6, 2);
            k    = $urandom_range(1, 4);
            mask = 4'b0001 << (k - 1);
            state = 4'(k + 1);
            key   = mask;
            repeat (KEY_LAT) next_cycle();
            @(negedge clk);
            exp_s = (r + 1 < 255) ? r + 1 : 255;
            checks++;
            if (control_signal !== 1'b1 || score !== 8'(exp_s)) begin
                errors++;
                $display("FAIL sat_hit round %0d got ctrl=%b score=%0d exp 1/%0d", r, control_signal, score, exp_s);
            end
            next_cycle();
            $display("sat round %0d: k=%0d score=%0d", r, k, score);
        end
        key = 4'd0;
        hold_state(4'd12, 2);
        checks++;
        if (score !== 8'd0 || misses !== 8'd0 || time_left !== 7'(GAME_SECONDS)) begin
            errors++;
            $display("FAIL undef_state got %0d/%0d/%0d exp 0/0/%0d", score, misses, time_left, GAME_SECONDS);
        end
    endtask

    // Reset asserted mid-mole clears everything at once; a fresh mole follows.
    task automatic test_reset_midgame();
        int k;
        logic [3:0] mask;
        hold_state(4'd0, 2);
        hold_state(4'd1, 12);
        k    = $urandom_range(1, 4);
        mask = 4'b0001 << (k - 1);
        state = 4'(k + 1);
        key   = mask;
        repeat (KEY_LAT + 1) next_cycle();
        checks++;
        if (score !== 8'd1 || time_left !== 7'(GAME_SECONDS - 1) || mole_led !== mask) begin
            errors++;
            $display("FAIL pre_reset got score=%0d left=%0d led=%b exp 1/%0d/%b",
                     score, time_left, mole_led, GAME_SECONDS - 1, mask);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({control_signal, delay_done, timer_signal, mole_led} !== 7'd0 ||
            score !== 8'd0 || misses !== 8'd0 || time_left !== 7'(GAME_SECONDS)) begin
            errors++;
            $display("FAIL async_reset got ctrl=%b led=%b score=%0d misses=%0d left=%0d",
                     control_signal, mole_led, score, misses, time_left);
        end
        key = 4'd0;
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c <= MOLE_TICKS; c++) begin
            @(negedge clk);
            checks++;
            if (control_signal !== (c == MOLE_TICKS)) begin
                errors++;
                $display("FAIL post_reset_ctrl cycle %0d got %b exp %b", c, control_signal, c == MOLE_TICKS);
            end
            next_cycle();
        end
        checks++;
        if (misses !== 8'd1 || score !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_counts got %0d/%0d exp 0/1", score, misses);
        end
        $display("reset mid-mole: k=%0d misses=%0d", k, misses);
    endtask

    initial begin
        test_reset();
        test_gap();
        test_mole_random(24);
        test_timer();
        test_saturate();
        test_reset_midgame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mole_datapath.md
MOLE_DATAPATH -- requirements
Module: mole_datapath

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clock cycles per one-second game tick.
REQ-002 Parameter GAME_SECONDS, default 60, game length in seconds (1..127).
REQ-003 Parameter GAP_TICKS, default 25000000, cycles spent in Game state before the next mole is requested.
REQ-004 Parameter MOLE_TICKS, default 50000000, cycles a mole stays lit before it counts as a miss.
REQ-005 clk  input  1  system clock, 50 MHz.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 state  input  4  game state from the game FSM; encoding: 0 Start, 1 Game, 2-5 Mole1-Mole4, 6 GameOver.
REQ-008 key  input  4  raw mole buttons, active-high, asynchronous to clk; bit i corresponds to Mole(i+1).
REQ-009 control_signal  output  1  one-cycle pulse to the FSM: next mole (in Game) or mole finished (in Mole1-4).
REQ-010 timer_signal  output  1  level; game time expired.
REQ-011 delay_done  output  1  one-cycle pulse; the Game-state gap has elapsed.
REQ-012 mole_led  output  4  one-hot lit mole; bit i is high while state = Mole(i+1).
REQ-013 score  output  8  count of hit moles.
REQ-014 misses  output  8  count of timed-out moles.
REQ-015 time_left  output  7  seconds remaining.

Function
REQ-016 Each key bit SHALL pass through a 2-flop synchronizer; a hit event is the rising edge of the synchronized bit, one cycle wide.
REQ-017 Key-to-hit latency SHALL be 3 cycles from key going high to the internal hit pulse.
REQ-018 The prescaler SHALL count 0..CLK_HZ-1 only while state is Game or Mole1-4 and SHALL emit a one-cycle second tick on wrap; it SHALL be cleared in every other state.
REQ-019 In Start, time_left SHALL load GAME_SECONDS; on each second tick it SHALL decrement, saturating at 0.
REQ-020 timer_signal SHALL be high whenever time_left = 0 and state is not Start.
REQ-021 In Start, score and misses SHALL clear to 0.
REQ-022 In Game, the gap counter SHALL count to GAP_TICKS-1; on the terminal count, delay_done and control_signal SHALL both pulse for one cycle.
REQ-023 In Game with timer_signal high, no gap pulse SHALL be issued.
REQ-024 In Mole1-4, the mole counter SHALL count to MOLE_TICKS-1. A hit on the matching key SHALL pulse control_signal and increment score. Reaching the terminal count SHALL pulse control_signal and increment misses.
REQ-025 A hit on a non-matching key SHALL be ignored.
REQ-026 If a matching hit and the mole timeout occur in the same cycle, the hit SHALL win: one control pulse, score +1, misses unchanged.
REQ-027 If time_left reaches 0 in Mole1-4, control_signal SHALL pulse once with neither score nor misses changing; the mole is aborted.
REQ-028 score and misses SHALL saturate at 255.
REQ-029 After any control_signal pulse, further pulses SHALL be suppressed until the state input differs from its value at the pulse. This absorbs the FSM's registered input/output latency.
REQ-030 The gap and mole counters SHALL clear on every change of state.
REQ-031 All outputs SHALL be registered.
REQ-032 In GameOver, all counters except time_left, score and misses SHALL hold at 0. mole_led SHALL be 0.
REQ-033 Undefined state codes (7-15) SHALL be treated as Start.

Reset
REQ-034 Reset SHALL asynchronously set: control_signal 0, delay_done 0, timer_signal 0, mole_led 0, score 0, misses 0, time_left GAME_SECONDS; it SHALL also clear all counters, synchronizers and the suppress flag.
REQ-035 Reset asserted mid-game SHALL abandon any pending pulse; no control_signal pulse SHALL be emitted in the first cycle after release.

Structure
REQ-036 The state encoding constants (Start..GameOver) SHALL live in the shared package whack_pkg, which the game FSM also uses.
REQ-037 The synchronizer plus edge detector SHALL be the sub-module key_sync, instantiated once with width 4.

Verification
(All scenarios use CLK_HZ=10, GAME_SECONDS=3, GAP_TICKS=4, MOLE_TICKS=8.)
REQ-038 state=1 held -> delay_done and control_signal pulse once, 4 cycles after state becomes 1; no second pulse until state changes.
REQ-039 state=3, key[1] raised 2 cycles after entry -> control_signal pulse 3 cycles later; score 0->1; misses unchanged.
REQ-040 state=4, no key -> control_signal pulse on cycle 8; misses 0->1. Same run with key[3] pressed -> no effect. Matching hit landing on cycle 8 -> score +1 only.
REQ-041 Hold Game/Mole states for 30 cycles -> time_left steps 3,2,1,0 at 10-cycle intervals; timer_signal rises with time_left=0; a mole active at that moment aborts with one pulse and no score or misses change.
REQ-042 score preloaded to 255 by 255 hits, then one more hit -> score stays 255; reset asserted mid-mole -> all outputs at reset values immediately, time_left=3.
